// File: rtl/copcom_pkg.sv
// Shared COPCOM definitions: sequencer state encoding, status bit positions
// and the COPCOM register offsets also used by the MMI decode.
package copcom_pkg;

    typedef enum logic [3:0] {
        IDLE,
        INIT,
        LOAD,
        SEND,
        WAIT,
        CRCW,
        CRCH,
        CRCL,
        DONE
    } state_t;

    // What WAIT hands over to once COPCOM is ready again
    typedef enum logic [1:0] {
        TAIL_PAYLOAD,
        TAIL_CRC_LO,
        TAIL_END
    } tail_t;

    localparam int COPWRSTAT_RDY_BIT    = 0;
    localparam int COPCRCSTAT_VALID_BIT = 0;

    localparam logic [7:0] ADDR_COPWR      = 8'h00;
    localparam logic [7:0] ADDR_COPWRLN    = 8'h04;
    localparam logic [7:0] ADDR_COPWRSTAT  = 8'h08;
    localparam logic [7:0] ADDR_COPCRCI1   = 8'h0C;
    localparam logic [7:0] ADDR_COPCRCSTAT = 8'h10;
    localparam logic [7:0] ADDR_COPCRCO1   = 8'h14;
    localparam logic [7:0] ADDR_COPCRCO2   = 8'h18;

    function automatic logic [7:0] frame_len(input logic [7:0] payload, input bit crc_append);
        return payload + (crc_append ? 8'd2 : 8'd0);
    endfunction

endpackage

// File: rtl/copcom_byte_fifo.sv
// Byte FIFO with synchronous flush and a registered read port; the read
// register doubles as the sequencer's holding register for the popped byte.
module copcom_byte_fifo #(
    parameter int DEPTH = 16
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     flush_i,
    input  logic                     push_i,
    input  logic [7:0]               data_i,
    input  logic                     pop_i,
    output logic [7:0]               data_o,
    output logic                     full_o,
    output logic [$clog2(DEPTH):0]   level_o
);
    localparam int AW = $clog2(DEPTH);

    logic [7:0]    mem [DEPTH];
    logic [AW-1:0] wr_ptr_q;
    logic [AW-1:0] rd_ptr_q;
    logic [AW:0]   level_q;
    logic [7:0]    rd_data_q;
    logic          push_ok;
    logic          pop_ok;

    assign full_o  = (level_q == (AW+1)'(DEPTH));
    assign push_ok = push_i && !full_o;
    assign pop_ok  = pop_i && (level_q != '0);
    assign level_o = level_q;
    assign data_o  = rd_data_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            level_q  <= '0;
        end else if (flush_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            level_q  <= '0;
        end else begin
            if (push_ok) wr_ptr_q <= wr_ptr_q + AW'(1);
            if (pop_ok)  rd_ptr_q <= rd_ptr_q + AW'(1);
            case ({push_ok, pop_ok})
                2'b10:   level_q <= level_q + (AW+1)'(1);
                2'b01:   level_q <= level_q - (AW+1)'(1);
                default: level_q <= level_q;
            endcase
        end
    end

    // Storage and read register carry no reset so they map onto block RAM
    always_ff @(posedge clk) begin
        if (push_ok && !flush_i) mem[wr_ptr_q] <= data_i;
        if (pop_ok)              rd_data_q    <= mem[rd_ptr_q];
    end

endmodule

// File: rtl/copcom_tx_sequencer.sv
// Streams a buffered byte frame into COPCOM: programs the length, feeds each
// byte through the CRC engine, then optionally appends the 16-bit CRC.
module copcom_tx_sequencer
    import copcom_pkg::*;
#(
    parameter int          DEPTH      = 16,
    parameter int          CRC_APPEND = 1,
    parameter logic [15:0] CRC_INIT   = 16'hFFFF,
    parameter int          TIMEOUT    = 1023
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     wr_valid,
    input  logic [7:0]               wr_data,
    output logic                     wr_ready,
    input  logic                     start,
    input  logic                     abort,
    output logic                     busy,
    output logic                     done,
    output logic                     err_timeout,
    output logic [$clog2(DEPTH):0]   level,
    output logic [7:0]               copwr_o,
    output logic                     copwren_o,
    output logic [7:0]               copwrln_o,
    input  logic [7:0]               copwrstat_i,
    output logic                     copcrcen_o,
    output logic                     copcrcinit_o,
    output logic [7:0]               copcrcinit1_o,
    output logic [7:0]               copcrcinit2_o,
    output logic [7:0]               copcrci1_o,
    input  logic [7:0]               copcrcstat_i,
    input  logic [7:0]               copcrco1_i,
    input  logic [7:0]               copcrco2_i
);
    localparam int LW = $clog2(DEPTH) + 1;
    localparam int TW = $clog2(TIMEOUT + 1);
    localparam logic [TW-1:0] TMO_LOAD = TW'(TIMEOUT);
    localparam bit APPEND = (CRC_APPEND != 0);

    state_t          state_q;
    tail_t           tail_q;
    logic            skip_q;
    logic [LW-1:0]   len_q;
    logic [LW-1:0]   remaining_q;
    logic [TW-1:0]   tmo_q;
    logic [15:0]     crc_q;
    logic            err_q;
    logic [7:0]      copwr_q;
    logic [7:0]      copcrci1_q;
    logic [7:0]      copwrln_q;
    logic            copwren_q;
    logic            copcrcen_q;
    logic            copcrcinit_q;
    logic            done_q;

    logic            wr_rdy;
    logic            crc_vld;
    logic            waiting;
    logic            tmo_fire;
    logic            fifo_push;
    logic            fifo_pop;
    logic            fifo_flush;
    logic            fifo_full;
    logic [7:0]      fifo_data;
    logic [LW-1:0]   fifo_level;
    logic            unused_stat_bits;

    assign wr_rdy           = copwrstat_i[COPWRSTAT_RDY_BIT];
    assign crc_vld          = copcrcstat_i[COPCRCSTAT_VALID_BIT];
    assign unused_stat_bits = ^{copwrstat_i[7:1], copcrcstat_i[7:1]};

    always_comb begin
        waiting = 1'b0;
        case (state_q)
            SEND, CRCH, CRCL: waiting = !wr_rdy;
            WAIT:             waiting = !skip_q && !wr_rdy;
            CRCW:             waiting = !crc_vld;
            default:          waiting = 1'b0;
        endcase
        tmo_fire   = waiting && (tmo_q == '0);
        fifo_flush = abort || tmo_fire;
        fifo_pop   = (state_q == LOAD) && !abort;
        fifo_push  = wr_valid && !abort;
    end

    copcom_byte_fifo #(.DEPTH(DEPTH)) u_fifo (
        .clk     (clk),
        .rst_n   (rst_n),
        .flush_i (fifo_flush),
        .push_i  (fifo_push),
        .data_i  (wr_data),
        .pop_i   (fifo_pop),
        .data_o  (fifo_data),
        .full_o  (fifo_full),
        .level_o (fifo_level)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= IDLE;
            tail_q       <= TAIL_PAYLOAD;
            skip_q       <= 1'b0;
            len_q        <= '0;
            remaining_q  <= '0;
            tmo_q        <= '0;
            crc_q        <= '0;
            err_q        <= 1'b0;
            copwr_q      <= '0;
            copcrci1_q   <= '0;
            copwrln_q    <= '0;
            copwren_q    <= 1'b0;
            copcrcen_q   <= 1'b0;
            copcrcinit_q <= 1'b0;
            done_q       <= 1'b0;
        end else begin
            copwren_q    <= 1'b0;
            copcrcen_q   <= 1'b0;
            copcrcinit_q <= 1'b0;
            done_q       <= 1'b0;
            if (abort) begin
                state_q <= IDLE;
            end else if (tmo_fire) begin
                state_q <= IDLE;
                err_q   <= 1'b1;
            end else begin
                case (state_q)
                    IDLE: if (start && fifo_level != '0) begin
                        len_q       <= fifo_level;
                        remaining_q <= fifo_level;
                        err_q       <= 1'b0;
                        state_q     <= INIT;
                    end
                    INIT: begin
                        copwrln_q    <= frame_len(8'(len_q), APPEND);
                        copcrcinit_q <= 1'b1;
                        state_q      <= LOAD;
                    end
                    LOAD: begin
                        tmo_q   <= TMO_LOAD;
                        state_q <= SEND;
                    end
                    SEND: if (wr_rdy) begin
                        copwr_q     <= fifo_data;
                        copcrci1_q  <= fifo_data;
                        copwren_q   <= 1'b1;
                        copcrcen_q  <= 1'b1;
                        remaining_q <= remaining_q - LW'(1);
                        tail_q      <= TAIL_PAYLOAD;
                        skip_q      <= 1'b1;
                        tmo_q       <= TMO_LOAD;
                        state_q     <= WAIT;
                    end else begin
                        tmo_q <= tmo_q - TW'(1);
                    end
                    // Status from before our own write may still read ready, so skip one cycle
                    WAIT: if (skip_q) begin
                        skip_q <= 1'b0;
                    end else if (wr_rdy) begin
                        tmo_q <= TMO_LOAD;
                        case (tail_q)
                            TAIL_CRC_LO: state_q <= CRCL;
                            TAIL_END:    state_q <= DONE;
                            default:     state_q <= (remaining_q != '0) ? LOAD :
                                                    (APPEND ? CRCW : DONE);
                        endcase
                    end else begin
                        tmo_q <= tmo_q - TW'(1);
                    end
                    CRCW: if (crc_vld) begin
                        crc_q   <= {copcrco1_i, copcrco2_i};
                        tmo_q   <= TMO_LOAD;
                        state_q <= CRCH;
                    end else begin
                        tmo_q <= tmo_q - TW'(1);
                    end
                    CRCH, CRCL: if (wr_rdy) begin
                        copwr_q   <= (state_q == CRCH) ? crc_q[15:8] : crc_q[7:0];
                        copwren_q <= 1'b1;
                        tail_q    <= (state_q == CRCH) ? TAIL_CRC_LO : TAIL_END;
                        skip_q    <= 1'b1;
                        tmo_q     <= TMO_LOAD;
                        state_q   <= WAIT;
                    end else begin
                        tmo_q <= tmo_q - TW'(1);
                    end
                    DONE: begin
                        done_q  <= 1'b1;
                        state_q <= IDLE;
                    end
                    default: state_q <= IDLE;
                endcase
            end
        end
    end

    assign wr_ready      = !fifo_full;
    assign level         = fifo_level;
    assign busy          = (state_q != IDLE);
    assign done          = done_q;
    assign err_timeout   = err_q;
    assign copwr_o       = copwr_q;
    assign copwren_o     = copwren_q;
    assign copwrln_o     = copwrln_q;
    assign copcrcen_o    = copcrcen_q;
    assign copcrcinit_o  = copcrcinit_q;
    assign copcrci1_o    = copcrci1_q;
    assign copcrcinit1_o = CRC_INIT[15:8];
    assign copcrcinit2_o = CRC_INIT[7:0];

endmodule
